// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs one req/ack transaction to
// instruction memory at a time and hands the buffered word to decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [5:0]  inst_opcode,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirAligned;

  assign redirAligned = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      fa_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      word_q  <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      tgt_q   <= tgt_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
    end
  end

  // DISCARD keeps fa on the bus until the abandoned request is acknowledged.
  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    tgt_d   = tgt_q;
    word_d  = word_q;
    pc_d    = pc_q;
    unique case (state_q)
      START: begin
        state_d = FETCH;
        if (redirect_valid) fa_d = redirAligned;
      end
      FETCH: begin
        if (redirect_valid && imem_ack) begin
          fa_d = redirAligned;
        end else if (redirect_valid) begin
          tgt_d   = redirAligned;
          state_d = DISCARD;
        end else if (imem_ack) begin
          word_d  = imem_rdata;
          pc_d    = fa_q;
          fa_d    = fa_q + 32'd4;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          fa_d    = redirAligned;
          state_d = FETCH;
        end else if (inst_ready) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          fa_d    = redirect_valid ? redirAligned : tgt_q;
          state_d = FETCH;
        end else if (redirect_valid) begin
          tgt_d = redirAligned;
        end
      end
      default: state_d = START;
    endcase
  end

  assign imem_req      = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr     = fa_q;
  assign inst_valid    = (state_q == HOLD);
  assign inst_word     = word_q;
  assign inst_opcode   = word_q[31:26];
  assign inst_pc       = pc_q;
  assign inst_pc_plus4 = pc_q + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scripted vector table,
// a reset-during-discard sequence, and a randomized run against a model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_word;
  logic [5:0]  inst_opcode;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int compared = 0;
  int mismatched = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_opcode    (inst_opcode),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc;
    logic [31:0] ePc4;
    logic [5:0]  eOpc;
  } vec_t;

  vec_t vecQ[$];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata,
                              input logic ready, input logic redir,
                              input logic [31:0] rpc, input logic eReq,
                              input logic [31:0] eAddr, input logic eValid,
                              input logic [31:0] ePc, input logic [31:0] ePc4,
                              input logic [5:0] eOpc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid;
    v.ePc = ePc; v.ePc4 = ePc4; v.eOpc = eOpc;
    return v;
  endfunction

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic redir,
                               input logic [31:0] rpc);
    imem_ack       = ack;
    imem_rdata     = rdata;
    inst_ready     = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkCore(input string tag, input logic eReq,
                           input logic [31:0] eAddr, input logic eValid,
                           input logic [31:0] ePc, input logic [31:0] ePc4,
                           input logic [5:0] eOpc);
    checkOutput({tag, " imem_req"},      {31'h0, imem_req},      {31'h0, eReq});
    checkOutput({tag, " imem_addr"},     imem_addr,              eAddr);
    checkOutput({tag, " inst_valid"},    {31'h0, inst_valid},    {31'h0, eValid});
    checkOutput({tag, " inst_pc"},       inst_pc,                ePc);
    checkOutput({tag, " inst_pc_plus4"}, inst_pc_plus4,          ePc4);
    checkOutput({tag, " inst_opcode"},   {26'h0, inst_opcode},   {26'h0, eOpc});
  endtask

  // Reference model: tracks "request outstanding", "request abandoned",
  // and "instruction buffered" as independent facts rather than a state.
  bit          mStarted, mReq, mAbandon, mHave;
  logic [31:0] mAddr, mTgt, mWord, mPc;

  task automatic modelReset();
    mStarted = 0; mReq = 0; mAbandon = 0; mHave = 0;
    mAddr = 32'h0; mTgt = 32'h0; mWord = 32'h0; mPc = 32'h0;
  endtask

  task automatic modelStep(input logic ack, input logic [31:0] rdata,
                           input logic ready, input logic redir,
                           input logic [31:0] rpcRaw);
    logic [31:0] rpc;
    rpc = {rpcRaw[31:2], 2'b00};
    if (!mStarted) begin
      mStarted = 1;
      mReq = 1;
      if (redir) mAddr = rpc;
    end else if (mReq && !mAbandon) begin
      if (ack && redir) mAddr = rpc;
      else if (redir) begin mTgt = rpc; mAbandon = 1; end
      else if (ack) begin
        mHave = 1; mWord = rdata; mPc = mAddr; mAddr = mAddr + 4; mReq = 0;
      end
    end else if (mReq) begin
      if (ack) begin mAddr = redir ? rpc : mTgt; mAbandon = 0; end
      else if (redir) mTgt = rpc;
    end else begin
      if (redir) begin mHave = 0; mAddr = rpc; mReq = 1; end
      else if (ready) begin mHave = 0; mReq = 1; end
    end
  endtask

  initial begin
    vec_t v;
    logic        rAck, rReady, rRedir;
    logic [31:0] rData, rPc;

    // cycle-by-cycle script: expected outputs before the edge, then inputs
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4,   6'd0));
    vecQ.push_back(mk(1, 32'h8C000000, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4,   6'd0));
    vecQ.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h4,        1, 32'h0,        32'h4,   6'd35));
    vecQ.push_back(mk(1, 32'h20000001, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h4,   6'd35));
    vecQ.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h8,        1, 32'h4,        32'h8,   6'd8));
    vecQ.push_back(mk(1, 32'hFC000000, 1, 0, 32'h0,        1, 32'h8,        0, 32'h4,        32'h8,   6'd8));
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 32'hC,        1, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 32'hC,        1, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 32'hC,        1, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'hC,        1, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 32'hC,        0, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        0, 1, 32'h100,      1, 32'hC,        0, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 32'hC,        0, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 32'hC,        0, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(1, 32'hDEADBEEF, 0, 0, 32'h0,        1, 32'hC,        0, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(1, 32'h08000010, 0, 0, 32'h0,        1, 32'h100,      0, 32'h8,        32'hC,   6'd63));
    vecQ.push_back(mk(0, 32'h0,        1, 1, 32'h43,       0, 32'h104,      1, 32'h100,      32'h104, 6'd2));
    vecQ.push_back(mk(0, 32'h0,        0, 1, 32'h203,      1, 32'h40,       0, 32'h100,      32'h104, 6'd2));
    vecQ.push_back(mk(0, 32'h0,        0, 1, 32'h80,       1, 32'h40,       0, 32'h100,      32'h104, 6'd2));
    vecQ.push_back(mk(1, 32'h11111111, 0, 0, 32'h0,        1, 32'h40,       0, 32'h100,      32'h104, 6'd2));
    vecQ.push_back(mk(1, 32'h0C000000, 0, 0, 32'h0,        1, 32'h80,       0, 32'h100,      32'h104, 6'd2));
    vecQ.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h84,       1, 32'h80,       32'h84,  6'd3));
    vecQ.push_back(mk(1, 32'h04000000, 0, 1, 32'hFFFFFFFF, 1, 32'h84,       0, 32'h80,       32'h84,  6'd3));
    vecQ.push_back(mk(1, 32'h14000000, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h80,       32'h84,  6'd3));
    vecQ.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 32'h0,   6'd5));
    vecQ.push_back(mk(0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'hFFFFFFFC, 32'h0,   6'd5));

    $display("[TB] reset and scripted vectors");
    repeat (2) @(negedge clk);
    checkCore("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 6'd0);
    checkOutput("reset inst_word", inst_word, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < vecQ.size(); i++) begin
      v = vecQ[i];
      checkCore($sformatf("vec%0d", i), v.eReq, v.eAddr, v.eValid, v.ePc, v.ePc4, v.eOpc);
      applyStimulus(v.ack, v.rdata, v.ready, v.redir, v.rpc);
      @(negedge clk);
    end

    $display("[TB] reset asserted while discarding");
    applyStimulus(1, 32'h0, 0, 1, 32'h500);
    @(negedge clk);
    checkOutput("redirAck imem_addr", imem_addr, 32'h500);
    applyStimulus(0, 32'h0, 0, 1, 32'h600);
    @(negedge clk);
    checkOutput("discard imem_req", {31'h0, imem_req}, 32'h1);
    checkOutput("discard imem_addr", imem_addr, 32'h500);
    applyStimulus(0, 32'h0, 0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1 checkCore("asyncReset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 6'd0);
    checkOutput("asyncReset inst_word", inst_word, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("postReset start imem_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    checkOutput("postReset imem_req", {31'h0, imem_req}, 32'h1);
    checkOutput("postReset imem_addr", imem_addr, 32'h0);

    $display("[TB] randomized run against reference model");
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      checkCore($sformatf("rand%0d", c), mReq, mAddr, mHave, mPc, mPc + 32'd4, mWord[31:26]);
      checkOutput($sformatf("rand%0d inst_word", c), inst_word, mWord);
      rAck   = ($urandom_range(0, 1) == 1);
      rData  = $urandom;
      rReady = ($urandom_range(0, 9) < 6);
      rRedir = ($urandom_range(0, 9) == 0);
      rPc    = $urandom;
      applyStimulus(rAck, rData, rReady, rRedir, rPc);
      modelStep(rAck, rData, rReady, rRedir, rPc);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
